// File: rtl/wired_bus_arb_pkg.sv
// Shared types and helpers for the wired-bus round-robin arbiter.
// Holds the FSM state encoding and the multi-driver detection helper.
package wired_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } arb_state_t;

  // True when more than one bit is set: clearing the lowest set bit leaves something behind.
  function automatic logic popcount_gt1(input logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/wired_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
// Shared by the IDLE and end-of-turnaround decisions.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             valid,
  output logic [ID_W-1:0]  winner
);

  logic [ID_W-1:0] sel;

  // Walk from the farthest candidate to the nearest so the nearest hit overrides.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sel    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      sel = ID_W'((int'(last) + i) % N_REQ);
      if (req[sel]) begin
        valid  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/wired_bus_arbiter.sv
// Round-robin owner arbiter for a shared wired (trior/wand) net bundle, with turnaround
// gaps, bounded tenure under contention and sticky drive-contention monitoring.
module wired_bus_arbiter
  import wired_bus_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int TA_CYC   = 1,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] drv_en,
  input  logic             clr_err,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  owner_id,
  output logic             bus_busy,
  output logic             preempt,
  output logic             err_contention,
  output logic [1:0]       dbg_state
);

  localparam int TEN_W = $clog2(MAX_HOLD);
  localparam int TA_W  = (TA_CYC > 1) ? $clog2(TA_CYC) : 1;
  localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_HOLD - 1);
  localparam logic [TA_W-1:0]  TA_LAST = TA_W'(TA_CYC - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [TEN_W-1:0] tenure_q, tenure_d;
  logic [TA_W-1:0]  ta_q, ta_d;
  logic             preempt_q, preempt_d;
  logic             err_q, err_d;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_idx;
  logic             owner_req;
  logic             other_req;
  logic             contention;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .last   (owner_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign owner_req  = req[owner_q];
  assign other_req  = |(req & ~gnt_q);
  assign contention = popcount_gt1(16'(drv_en)) || (|(drv_en & ~gnt_q));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    tenure_d  = tenure_q;
    ta_d      = ta_q;
    preempt_d = 1'b0;
    err_d     = contention || (err_q && !clr_err);
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = GRANT;
          gnt_d    = N_REQ'(1) << pick_idx;
          owner_d  = pick_idx;
          tenure_d = '0;
        end
      end
      GRANT: begin
        // A voluntary drop wins over a same-cycle tenure expiry, so no preempt then.
        if (!owner_req) begin
          state_d = TURNAROUND;
          gnt_d   = '0;
          ta_d    = '0;
        end else if (tenure_q == TEN_MAX && other_req) begin
          state_d   = TURNAROUND;
          gnt_d     = '0;
          ta_d      = '0;
          preempt_d = 1'b1;
        end else if (tenure_q != TEN_MAX) begin
          tenure_d = tenure_q + 1'b1;
        end
      end
      TURNAROUND: begin
        if (ta_q == TA_LAST) begin
          if (pick_valid) begin
            state_d  = GRANT;
            gnt_d    = N_REQ'(1) << pick_idx;
            owner_d  = pick_idx;
            tenure_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ta_d = ta_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= ID_W'(N_REQ - 1);
      tenure_q  <= '0;
      ta_q      <= '0;
      preempt_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      tenure_q  <= tenure_d;
      ta_q      <= ta_d;
      preempt_q <= preempt_d;
      err_q     <= err_d;
    end
  end

  assign gnt            = gnt_q;
  assign owner_id       = owner_q;
  assign bus_busy       = |gnt_q;
  assign preempt        = preempt_q;
  assign err_contention = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Bench for wired_bus_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-level ownership model.
module tb_wired_bus_arbiter;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 8;
  localparam int TA_CYC   = 1;
  localparam int ID_W     = $clog2(N_REQ);

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] drv_en;
  logic             clr_err;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  owner_id;
  logic             bus_busy;
  logic             preempt;
  logic             err_contention;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, for how many cycles, and how much gap is left.
  int m_cur;
  int m_held;
  int m_gap;
  int m_last;
  logic m_err;
  logic m_pre;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    int         owner;
    logic       busy;
  } vec_t;
  vec_t tbl[10];

  wired_bus_arbiter #(.N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD), .TA_CYC(TA_CYC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .drv_en         (drv_en),
    .clr_err        (clr_err),
    .gnt            (gnt),
    .owner_id       (owner_id),
    .bus_busy       (bus_busy),
    .preempt        (preempt),
    .err_contention (err_contention),
    .dbg_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_REQ-1:0] exp_gnt();
    logic [N_REQ-1:0] g;
    g = '0;
    if (m_cur >= 0) g[m_cur] = 1'b1;
    return g;
  endfunction

  // Lowest requester above the last owner, otherwise the lowest requester overall.
  function automatic int rr_ref(input logic [N_REQ-1:0] r, input int last);
    for (int i = last + 1; i < N_REQ; i++) if (r[i]) return i;
    for (int i = 0; i < N_REQ; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_cur  = -1;
    m_held = 0;
    m_gap  = 0;
    m_last = N_REQ - 1;
    m_err  = 1'b0;
    m_pre  = 1'b0;
  endtask

  task automatic model_update();
    logic [N_REQ-1:0] g;
    logic set_err;
    int w;
    g = exp_gnt();
    set_err = ($countones(drv_en) > 1) || ((drv_en & ~g) != '0);
    m_err = set_err || (m_err && !clr_err);
    m_pre = 1'b0;
    if (m_cur >= 0) begin
      if (!req[m_cur]) begin
        m_cur = -1;
        m_gap = TA_CYC;
      end else if (m_held >= MAX_HOLD && (req & ~g) != '0) begin
        m_cur = -1;
        m_gap = TA_CYC;
        m_pre = 1'b1;
      end else if (m_held < MAX_HOLD) begin
        m_held++;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      w = rr_ref(req, m_last);
      if (w >= 0) begin
        m_cur  = w;
        m_held = 1;
        m_last = w;
      end
    end
  endtask

  task automatic compare_model();
    check("gnt", 32'(gnt), 32'(exp_gnt()));
    check("owner_id", 32'(owner_id), 32'(m_last));
    check("bus_busy", 32'(bus_busy), 32'(m_cur >= 0));
    check("preempt", 32'(preempt), 32'(m_pre));
    check("err_contention", 32'(err_contention), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    drv_en  = '0;
    clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_model();
  endtask

  initial begin
    tbl[0] = '{4'b0110, 4'b0010, 1, 1'b1};
    tbl[1] = '{4'b0110, 4'b0010, 1, 1'b1};
    tbl[2] = '{4'b0100, 4'b0000, 1, 1'b0};
    tbl[3] = '{4'b0100, 4'b0100, 2, 1'b1};
    tbl[4] = '{4'b0000, 4'b0000, 2, 1'b0};
    tbl[5] = '{4'b0000, 4'b0000, 2, 1'b0};
    tbl[6] = '{4'b1000, 4'b1000, 3, 1'b1};
    tbl[7] = '{4'b0000, 4'b0000, 3, 1'b0};
    tbl[8] = '{4'b0001, 4'b0001, 0, 1'b1};
    tbl[9] = '{4'b0000, 4'b0000, 0, 1'b0};

    do_reset();
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_owner", 32'(owner_id), 32'd3);
    check("reset_busy", 32'(bus_busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      step();
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_owner", i), 32'(owner_id), 32'(tbl[i].owner));
      check($sformatf("tbl%0d_busy", i), 32'(bus_busy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_pre", i), 32'(preempt), 32'd0);
    end

    // Tenure bound: two contenders alternate after MAX_HOLD cycles each.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < MAX_HOLD; i++) begin
      step();
      check("hold0_gnt", 32'(gnt), 32'b0001);
    end
    step();
    check("pre1_gnt", 32'(gnt), 32'd0);
    check("pre1_pulse", 32'(preempt), 32'd1);
    step();
    check("hold1_gnt", 32'(gnt), 32'b0010);
    check("hold1_pre", 32'(preempt), 32'd0);
    for (int i = 1; i < MAX_HOLD; i++) begin
      step();
      check("hold1_gnt", 32'(gnt), 32'b0010);
    end
    step();
    check("pre2_pulse", 32'(preempt), 32'd1);
    step();
    check("back0_gnt", 32'(gnt), 32'b0001);

    // Drop on the same cycle tenure expires is a normal release.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < MAX_HOLD; i++) step();
    req = 4'b0010;
    step();
    check("drop_at_max_gnt", 32'(gnt), 32'd0);
    check("drop_at_max_pre", 32'(preempt), 32'd0);
    step();
    check("drop_at_max_next", 32'(gnt), 32'b0010);

    // Lone requester keeps the bus indefinitely.
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 50; i++) begin
      step();
      check("solo_gnt", 32'(gnt), 32'b1000);
      check("solo_pre", 32'(preempt), 32'd0);
    end

    // Contention flag: set, sticky, set-beats-clear, clear, ungranted driver.
    do_reset();
    req = 4'b0001;
    step();
    drv_en = 4'b0011;
    step();
    check("cont_set", 32'(err_contention), 32'd1);
    drv_en = 4'b0001;
    step();
    check("cont_sticky", 32'(err_contention), 32'd1);
    drv_en = 4'b0011;
    clr_err = 1'b1;
    step();
    check("cont_set_wins", 32'(err_contention), 32'd1);
    drv_en = 4'b0001;
    step();
    check("cont_clear", 32'(err_contention), 32'd0);
    clr_err = 1'b0;
    drv_en = 4'b0100;
    step();
    check("cont_ungranted", 32'(err_contention), 32'd1);
    drv_en = 4'b0000;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Asynchronous reset mid-grant drops gnt between clock edges.
    do_reset();
    req = 4'b0001;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_busy", 32'(bus_busy), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    step();
    check("post_reset_gnt", 32'(gnt), 32'b0001);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) req = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      if ($urandom_range(0, 15) == 0) drv_en = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      else drv_en = exp_gnt();
      clr_err = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
